// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential Booth multiplier (signed/unsigned), radix-2 by default;
// define BOOTH_RADIX4_EN for radix-4 recoding with half the iterations.
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               neg
);
`ifdef BOOTH_RADIX4_EN
    localparam int EW   = WIDTH + 2 + (WIDTH % 2);
    localparam int ITER = EW / 2;
`else
    localparam int EW   = WIDTH + 1;
    localparam int ITER = WIDTH + 1;
`endif
    localparam int AW = EW + 1;
    localparam int CW = $clog2(ITER + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state;
    logic [AW-1:0] acc, acc_n, m_x, sum;
    logic [EW-1:0] m, q, q_n;
    logic q1, q1_n, sgn;
    logic [CW-1:0] cnt;
    logic [AW+EW-1:0] full_n;

    assign m_x    = {m[EW-1], m};
    assign full_n = {acc_n, q_n};
`ifdef BOOTH_RADIX4_EN
    logic [2:0] sel;
    logic [AW-1:0] mag;
    assign sel   = {q[1:0], q1};
    assign mag   = (sel == 3'b011 || sel == 3'b100) ? m_x << 1 : m_x;
    assign sum   = (sel == 3'b000 || sel == 3'b111) ? acc : sel[2] ? acc - mag : acc + mag;
    assign acc_n = {{2{sum[AW-1]}}, sum[AW-1:2]};
    assign q_n   = {sum[1:0], q[EW-1:2]};
    assign q1_n  = q[1];
`else
    assign sum   = (q[0] ^ q1) ? (q[0] ? acc - m_x : acc + m_x) : acc;
    assign acc_n = {sum[AW-1], sum[AW-1:1]};
    assign q_n   = {sum[0], q[EW-1:1]};
    assign q1_n  = q[0];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            neg     <= 1'b0;
            acc     <= '0;
            m       <= '0;
            q       <= '0;
            q1      <= 1'b0;
            sgn     <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    m     <= {{(EW-WIDTH){signed_mode & a[WIDTH-1]}}, a};
                    q     <= {{(EW-WIDTH){signed_mode & b[WIDTH-1]}}, b};
                    acc   <= '0;
                    q1    <= 1'b0;
                    sgn   <= signed_mode;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= CALC;
                end
                CALC: begin
                    acc <= acc_n;
                    q   <= q_n;
                    q1  <= q1_n;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(ITER - 1)) begin
                        product <= (2*WIDTH)'(full_n);
                        neg     <= sgn & full_n[2*WIDTH-1];
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: directed + random scoreboard bench for booth_mult_seq (WIDTH=8),
// handshake timing follows BOOTH_RADIX4_EN when defined.
module tb_booth_mult_seq;
    localparam int W = 8;
`ifdef BOOTH_RADIX4_EN
    localparam int ITER = (W + 2 + (W % 2)) / 2;
`else
    localparam int ITER = W + 1;
`endif

    logic clk = 1'b0, rst = 1'b0, start = 1'b0, signed_mode = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic busy, done, neg;
    logic [2*W-1:0] product;
    int n_cmp = 0, n_bad = 0;
    logic [2*W:0] sb_q[$];

    booth_mult_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy), .done(done), .product(product), .neg(neg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        longint px, py, p;
        logic [2*W-1:0] r;
        px = s ? longint'($signed(x)) : longint'(x);
        py = s ? longint'($signed(y)) : longint'(y);
        p  = px * py;
        r  = p[2*W-1:0];
        return {s & r[2*W-1], r};
    endfunction

    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        @(negedge clk);
        a = x; b = y; signed_mode = s; start = 1'b1;
        sb_q.push_back(model(x, y, s));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called just after a start edge; poke re-pulses start during CALC and DONE.
    task automatic wait_done(input bit poke);
        int k;
        logic [2*W:0] e;
        k = 0;
        while (k < ITER + 4) begin
            @(posedge clk); #1;
            k++;
            if (k == 1) chk("busy_rise", busy, 1);
            if (poke && k == 3) begin a = ~a; b = ~b; signed_mode = ~signed_mode; start = 1'b1; end
            if (poke && k == 4) start = 1'b0;
            if (done) break;
        end
        chk("latency", k, ITER);
        if (sb_q.size() > 0) e = sb_q.pop_front();
        else e = 'x;
        chk("product", product, e[2*W-1:0]);
        chk("neg", neg, e[2*W]);
        if (poke) start = 1'b1;
        @(posedge clk); #1;
        chk("done_pulse", done, 0);
        chk("busy_fall", busy, 0);
        if (poke) begin
            start = 1'b0;
            @(posedge clk); #1;
            chk("no_queue", busy, 0);
            chk("hold", product, e[2*W-1:0]);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_product", product, 0);
        chk("rst_neg", neg, 0);
        @(negedge clk);
        rst = 1'b1;
        launch(8'd3, 8'd4, 1'b0);    wait_done(0);
        launch(8'hFB, 8'h07, 1'b1);  wait_done(0);
        launch(8'hFB, 8'h07, 1'b0);  wait_done(0);
        launch(8'h80, 8'h80, 1'b1);  wait_done(0);
        launch(8'hFF, 8'hFF, 1'b0);  wait_done(0);
        launch(8'hFF, 8'hFF, 1'b1);  wait_done(0);
        launch(8'h7F, 8'h80, 1'b1);  wait_done(0);
        launch(8'h00, 8'h9C, 1'b1);  wait_done(0);
        launch(8'h12, 8'h34, 1'b0);  wait_done(1);
        // start held high across done: second operation begins on the first idle edge
        @(negedge clk);
        a = 8'hC3; b = 8'h5A; signed_mode = 1'b1; start = 1'b1;
        sb_q.push_back(model(8'hC3, 8'h5A, 1'b1));
        sb_q.push_back(model(8'hC3, 8'h5A, 1'b1));
        @(posedge clk); #1;
        wait_done(0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_busy", busy, 1);
        wait_done(0);
        launch(8'h55, 8'h66, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_product", product, 0);
        chk("arst_neg", neg, 0);
        void'(sb_q.pop_back());
        repeat (3) begin
            @(posedge clk); #1;
            chk("arst_nodone", done, 0);
        end
        @(negedge clk);
        rst = 1'b1;
        launch(8'h55, 8'h66, 1'b0);  wait_done(0);
        for (int i = 0; i < 60; i++) begin
            launch(8'($urandom), 8'($urandom), i[0]);
            wait_done(0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
